ltc_tick_sched: RTL and testbench

Bit-cell scheduler for the LTC generator: turns the system clock into exact half-bit-cell strobes for the biphase-mark serializer and the per-frame counter-advance strobe. It sits between the top-level pins (frame-rate select, run enable) and the LTC datapath. Rates are derived with a phase accumulator, so long-term timing is exact for any clock frequency, including 29.97 fps. Frame-rate changes and stop requests take effect only on frame boundaries.

---
 rtl/ltc_tick_sched_if.sv | 24 ++
 rtl/ltc_tick_sched.sv | 149 ++++++++++++++
 tb/tb_ltc_tick_sched.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ltc_tick_sched_if.sv
// Control and strobe bundle between the LTC pins/datapath and ltc_tick_sched.
// half_tick and frame_start are one-cycle strobes with no back-pressure: every strobe must be consumed in its cycle.
interface ltc_tick_sched_if;
    logic       run;
    logic [1:0] rate_sel;
    logic       half_tick;
    logic [6:0] bit_idx;
    logic       half;
    logic       frame_start;
    logic [1:0] rate_active;
    logic       busy;
    logic       drop_frame;
    logic [1:0] dbg_state;

    modport master (
        output run, rate_sel,
        input  half_tick, bit_idx, half, frame_start, rate_active, busy, drop_frame, dbg_state
    );

    modport slave (
        input  run, rate_sel,
        output half_tick, bit_idx, half, frame_start, rate_active, busy, drop_frame, dbg_state
    );
endinterface

// File: rtl/ltc_tick_sched.sv
// ltc_tick_sched: phase-accumulator scheduler producing half-bit-cell and frame strobes for LTC.
// Build option LTC_DROPFRAME_EN: rate_sel 2'b10 runs at 29.97 fps and raises drop_frame.
module ltc_tick_sched #(
    parameter int unsigned CLK_HZ = 10_000_000,
    parameter int unsigned ACC_W  = 40
) (
    input  logic            clk,
    input  logic            reset,
    ltc_tick_sched_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] MOD      = ACC_W'(64'(CLK_HZ) * 64'd1001);
    localparam logic [7:0]       POS_LAST = 8'd159;

    function automatic logic [ACC_W-1:0] step_for(input logic [1:0] rate);
        case (rate)
            2'b00:   step_for = ACC_W'(32'd3843840);
            2'b01:   step_for = ACC_W'(32'd4004000);
`ifdef LTC_DROPFRAME_EN
            2'b10:   step_for = ACC_W'(32'd4800000);
`else
            2'b10:   step_for = ACC_W'(32'd4804800);
`endif
            default: step_for = ACC_W'(32'd4804800);
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       pos_q, pos_d;
    logic [1:0]       cell_rate_q, cell_rate_d;
    logic [1:0]       rate_active_q, rate_active_d;
    logic             half_tick_q, half_tick_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;
    logic             drop_frame_q, drop_frame_d;

    logic [ACC_W-1:0] acc_sum;
    logic             acc_wrap;
    logic [7:0]       pos_next;

    // cell_rate steps the accumulator and swaps only at frame_start, so the
    // last half-cell of a frame still runs at the rate that frame started with.
    always_comb begin
        acc_sum  = acc_q + step_for(cell_rate_q);
        acc_wrap = (acc_sum >= MOD);
        pos_next = (pos_q == POS_LAST) ? 8'd0 : pos_q + 8'd1;
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        pos_d         = pos_q;
        cell_rate_d   = cell_rate_q;
        rate_active_d = rate_active_q;
        half_tick_d   = 1'b0;
        frame_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                pos_d = '0;
                if (bus.run) begin
                    state_d       = ST_RUN;
                    half_tick_d   = 1'b1;
                    frame_start_d = 1'b1;
                    rate_active_d = bus.rate_sel;
                    cell_rate_d   = bus.rate_sel;
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (acc_wrap) begin
                    acc_d         = acc_sum - MOD;
                    pos_d         = pos_next;
                    half_tick_d   = 1'b1;
                    frame_start_d = (pos_next == 8'd0);
                    if (pos_next == POS_LAST) begin
                        rate_active_d = bus.rate_sel;
                    end
                    if (pos_next == 8'd0) begin
                        cell_rate_d = rate_active_q;
                    end
                end else begin
                    acc_d = acc_sum;
                end

                if (state_q == ST_RUN) begin
                    if (!bus.run) begin
                        state_d = ST_STOPPING;
                    end
                end else if (bus.run) begin
                    state_d = ST_RUN;
                end else if (acc_wrap && (pos_next == POS_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
`ifdef LTC_DROPFRAME_EN
        drop_frame_d = (rate_active_d == 2'b10);
`else
        drop_frame_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            pos_q         <= '0;
            cell_rate_q   <= '0;
            rate_active_q <= '0;
            half_tick_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            drop_frame_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            pos_q         <= pos_d;
            cell_rate_q   <= cell_rate_d;
            rate_active_q <= rate_active_d;
            half_tick_q   <= half_tick_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            drop_frame_q  <= drop_frame_d;
        end
    end

    assign bus.half_tick   = half_tick_q;
    assign bus.bit_idx     = pos_q[7:1];
    assign bus.half        = pos_q[0];
    assign bus.frame_start = frame_start_q;
    assign bus.rate_active = rate_active_q;
    assign bus.busy        = busy_q;
    assign bus.drop_frame  = drop_frame_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_ltc_tick_sched.sv
// Bench for ltc_tick_sched: directed frame-timing scenarios plus random run/rate traffic,
// checked every cycle against a cumulative-phase reference model.
module tb_ltc_tick_sched;

    localparam int unsigned CLK_HZ = 40000;
    localparam longint      MOD    = 64'd40040000;
`ifdef LTC_DROPFRAME_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ltc_tick_sched_if bus ();

    ltc_tick_sched #(.CLK_HZ(CLK_HZ), .ACC_W(40)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int last_fs = 0, prev_fs = 0, last_tk = 0, prev_tk = 0;

    // Reference model: total phase since run start; a tick is owed whenever
    // the total passes the next multiple of MOD.
    int         m_mode;   // 0 idle, 1 run, 2 stopping
    longint     m_total, m_ticks;
    int         m_pos;
    logic [1:0] m_ra, m_cell;
    logic       m_ht, m_fs;

    function automatic longint step_of(input logic [1:0] r);
        case (r)
            2'b00:   return 64'd24024 * 160;
            2'b01:   return 64'd25025 * 160;
            2'b10:   return DROP ? 64'd30000 * 160 : 64'd30030 * 160;
            default: return 64'd30030 * 160;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_total = 0; m_ticks = 0; m_pos = 0;
        m_ra = 2'b00; m_cell = 2'b00; m_ht = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_edge();
        int  prev_mode;
        bit  tick;
        if (reset) begin
            model_reset();
            return;
        end
        m_ht = 1'b0;
        m_fs = 1'b0;
        if (m_mode == 0) begin
            m_pos = 0;
            if (bus.run) begin
                m_mode = 1; m_ht = 1'b1; m_fs = 1'b1;
                m_ra = bus.rate_sel; m_cell = bus.rate_sel;
                m_total = 0; m_ticks = 0;
            end
        end else begin
            prev_mode = m_mode;
            m_total += step_of(m_cell);
            tick = (m_total >= (m_ticks + 1) * MOD);
            if (tick) begin
                m_ticks++;
                m_pos = (m_pos + 1) % 160;
                m_ht = 1'b1;
                m_fs = (m_pos == 0);
                if (m_pos == 159) m_ra = bus.rate_sel;
                if (m_pos == 0) m_cell = m_ra;
            end
            if (prev_mode == 1) begin
                if (!bus.run) m_mode = 2;
            end else if (bus.run) begin
                m_mode = 1;
            end else if (tick && m_pos == 159) begin
                m_mode = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic check_all();
        chk("half_tick",   32'(bus.half_tick),   32'(m_ht));
        chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
        chk("bit_idx",     32'(bus.bit_idx),     32'(m_pos / 2));
        chk("half",        32'(bus.half),        32'(m_pos % 2));
        chk("rate_active", 32'(bus.rate_active), 32'(m_ra));
        chk("busy",        32'(bus.busy),        32'(m_mode != 0));
        chk("drop_frame",  32'(bus.drop_frame),  32'(DROP && (m_ra == 2'b10)));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        cyc_n++;
        check_all();
        if (bus.frame_start) begin prev_fs = last_fs; last_fs = cyc_n; end
        if (bus.half_tick) begin prev_tk = last_tk; last_tk = cyc_n; end
    endtask

    task automatic wait_tick_pos(input int p, input int bound);
        bit found = 1'b0;
        for (int n = 0; n < bound && !found; n++) begin
            cyc();
            if (bus.half_tick && (int'({bus.bit_idx, bus.half}) == p)) found = 1'b1;
        end
        chk($sformatf("wait_pos%0d", p), 32'(found), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        bit idle = 1'b0;
        for (int n = 0; n < bound && !idle; n++) begin
            cyc();
            if (!bus.busy) idle = 1'b1;
        end
        chk("wait_idle", 32'(idle), 32'd1);
    endtask

    task automatic measure_span(input logic [1:0] r, input int exp_span, input logic exp_drop, input string tag);
        int start;
        int nfs = 0;
        bus.rate_sel = r;
        bus.run = 1'b1;
        cyc();
        start = cyc_n;
        chk({tag, ".first_fs"}, 32'(bus.frame_start), 32'd1);
        for (int n = 0; n < 6000 && nfs < 3; n++) begin
            cyc();
            if (bus.frame_start) nfs++;
        end
        chk({tag, ".frames"}, 32'(nfs), 32'd3);
        chk({tag, ".span"}, 32'(last_fs - start), 32'(exp_span));
        chk({tag, ".drop"}, 32'(bus.drop_frame), 32'(exp_drop));
        bus.run = 1'b0;
        wait_idle(4000);
    endtask

    initial begin
        int bad, fs_bad, nfs, max_bit, last_pos, quiet, busy_low, start;
        bit done;

        // Reset state
        reset = 1'b1;
        bus.run = 1'b0;
        bus.rate_sel = 2'b00;
        model_reset();
        cyc();
        cyc();
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.pos", 32'({bus.bit_idx, bus.half}), 32'd0);
        reset = 1'b0;
        repeat (5) cyc();

        // 25 fps: tick every 10 cycles, frame every 1600, bit_idx 0..79
        bus.rate_sel = 2'b01;
        bus.run = 1'b1;
        cyc();
        chk("r25.first_fs", 32'(bus.frame_start), 32'd1);
        bad = 0; fs_bad = 0; nfs = 0; max_bit = 0;
        for (int n = 0; n < 3200; n++) begin
            cyc();
            if (bus.half_tick) begin
                if (last_tk - prev_tk != 10) bad++;
                if (int'(bus.bit_idx) > max_bit) max_bit = int'(bus.bit_idx);
            end
            if (bus.frame_start) begin
                nfs++;
                if (last_fs - prev_fs != 1600) fs_bad++;
            end
        end
        chk("r25.tick_spacing_bad", 32'(bad), 32'd0);
        chk("r25.frames", 32'(nfs), 32'd2);
        chk("r25.frame_len_bad", 32'(fs_bad), 32'd0);
        chk("r25.max_bit", 32'(max_bit), 32'd79);

        // Mid-frame rate change waits for the frame boundary
        wait_tick_pos(80, 2000);
        bus.rate_sel = 2'b11;
        wait_tick_pos(159, 2000);
        chk("chg.ra_at_159", 32'(bus.rate_active), 32'd3);
        wait_tick_pos(0, 100);
        chk("chg.frame_len", 32'(last_fs - prev_fs), 32'd1600);

        // Stop request: frame completes through pos 159, then silence
        wait_tick_pos(40, 2000);
        bus.run = 1'b0;
        done = 1'b0; last_pos = -1;
        for (int n = 0; n < 3000 && !done; n++) begin
            cyc();
            if (bus.half_tick) last_pos = int'({bus.bit_idx, bus.half});
            if (!bus.busy) done = 1'b1;
        end
        chk("stop.done", 32'(done), 32'd1);
        chk("stop.last_pos", 32'(last_pos), 32'd159);
        quiet = 0;
        repeat (300) begin
            cyc();
            quiet += int'(bus.half_tick) + int'(bus.frame_start);
        end
        chk("stop.quiet", 32'(quiet), 32'd0);

        // Long-term exact spans from a fresh start
        measure_span(2'b11, 4000, 1'b0, "r30");
        measure_span(2'b00, 5000, 1'b0, "r24");
        measure_span(2'b10, DROP ? 4004 : 4000, DROP, "r2997");

        // Stop at pos 40, re-raise at pos 100: uninterrupted stream
        bus.rate_sel = 2'b01;
        bus.run = 1'b1;
        cyc();
        start = cyc_n;
        bad = 0; busy_low = 0; done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            cyc();
            if (!bus.busy) busy_low++;
            if (bus.half_tick) begin
                if (last_tk - prev_tk != 10) bad++;
                if ({bus.bit_idx, bus.half} == 8'd40) bus.run = 1'b0;
                if ({bus.bit_idx, bus.half} == 8'd100) bus.run = 1'b1;
                if (bus.frame_start) done = 1'b1;
            end
        end
        chk("rerun.next_fs", 32'(done), 32'd1);
        chk("rerun.frame_len", 32'(last_fs - start), 32'd1600);
        chk("rerun.spacing_bad", 32'(bad), 32'd0);
        chk("rerun.busy_low", 32'(busy_low), 32'd0);

        // Asynchronous reset mid-frame at pos 70
        wait_tick_pos(70, 2000);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("areset.pos", 32'({bus.bit_idx, bus.half}), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("areset.fs_after", 32'(bus.frame_start), 32'd1);

        // Random run/rate traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 49) == 0) bus.rate_sel = 2'($urandom_range(0, 3));
            cyc();
        end
        bus.run = 1'b0;
        wait_idle(4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
